// File: rtl/tdpu_vec_acc_core_pkg.sv
// Shared types and helpers for the TDPU ternary dot-product core.
// Holds the ternary weight encoding and the accumulator limiter.
package tdpu_vec_acc_core_pkg;

    // 2'b10 is reserved and decodes as zero
    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_NEG  = 2'b11
    } weight_t;

    typedef struct packed {
        logic              ovf;
        logic signed [63:0] val;
    } acc_res_t;

    // Clamp or pass through a wide sum against an aw-bit signed range
    function automatic acc_res_t acc_limit(
        input logic signed [63:0] sum,
        input int unsigned        aw,
        input logic               sat
    );
        acc_res_t           r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.ovf = (sum > hi) || (sum < lo);
        r.val = sum;
        if (sat && (sum > hi)) begin
            r.val = hi;
        end else if (sat && (sum < lo)) begin
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdpu_vec_acc_core_add_tree.sv
// Registered pairwise adder tree with a sideband that travels with the data.
// Each level grows by one bit, so the reduction is exact.
module tdpu_add_tree #(
    parameter int LEN      = 16,
    parameter int IN_WIDTH = 9,
    parameter int SB_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [LEN-1:0][IN_WIDTH-1:0]  in_data,
    input  logic [SB_W-1:0]               in_sb,
    output logic                          out_valid,
    output logic [IN_WIDTH+$clog2(LEN)-1:0] out_sum,
    output logic [SB_W-1:0]               out_sb
);

    localparam int LVL = $clog2(LEN);

    genvar k;
    for (k = 0; k < LVL; k++) begin : g_lvl
        localparam int N = LEN >> (k + 1);
        localparam int W = IN_WIDTH + k + 1;

        logic [2*N-1:0][W-2:0] src;
        logic                  src_v;
        logic [SB_W-1:0]       src_sb;
        logic [N-1:0][W-1:0]   sum;
        logic                  v;
        logic [SB_W-1:0]       sb;

        if (k == 0) begin : g_src
            assign src    = in_data;
            assign src_v  = in_valid;
            assign src_sb = in_sb;
        end else begin : g_src
            assign src    = g_lvl[k-1].sum;
            assign src_v  = g_lvl[k-1].v;
            assign src_sb = g_lvl[k-1].sb;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v   <= 1'b0;
                sb  <= '0;
                sum <= '0;
            end else if (en) begin
                v  <= src_v;
                sb <= src_sb;
                for (int j = 0; j < N; j++) begin
                    sum[j] <= {src[2*j][W-2], src[2*j]}
                            + {src[2*j+1][W-2], src[2*j+1]};
                end
            end
        end
    end

    assign out_valid = g_lvl[LVL-1].v;
    assign out_sum   = g_lvl[LVL-1].sum[0];
    assign out_sb    = g_lvl[LVL-1].sb;

endmodule

// File: rtl/tdpu_vec_acc_core.sv
// Ternary dot-product core: PE stage, registered adder tree, group
// accumulator with double-buffered weights and valid/ready backpressure.
module tdpu_vec_acc_core
    import tdpu_vec_acc_core_pkg::*;
#(
    parameter int LEN        = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SAT_EN     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [LEN-1:0][DATA_WIDTH-1:0] i_data,
    input  logic                           i_first,
    input  logic                           i_last,
    input  logic                           i_load_weight,
    input  weight_t [LEN-1:0]              i_weight,
    input  logic                           i_wswap,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [ACC_WIDTH-1:0]           o_result,
    output logic                           o_overflow,
    output logic [15:0]                    o_beats
);

    localparam int LVL   = $clog2(LEN);
    localparam int PE_W  = DATA_WIDTH + 1;
    localparam int SUM_W = PE_W + LVL;

    logic en;
    logic accept;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;
    assign accept  = i_valid && en;

    weight_t [LEN-1:0] act_q;
    weight_t [LEN-1:0] shd_q;

    // Load and swap are independent of the pipeline stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                act_q[i] <= W_ZERO;
                shd_q[i] <= W_ZERO;
            end
        end else begin
            if (i_load_weight) begin
                shd_q <= i_weight;
            end
            if (i_wswap) begin
                act_q <= i_load_weight ? i_weight : shd_q;
            end
        end
    end

    logic [LEN-1:0][PE_W-1:0] pe_d;
    logic [LEN-1:0][PE_W-1:0] pe_q;
    logic                     pe_v;
    logic [1:0]               pe_sb;

    always_comb begin
        pe_d = '0;
        for (int i = 0; i < LEN; i++) begin
            case (act_q[i])
                W_POS:   pe_d[i] = {i_data[i][DATA_WIDTH-1], i_data[i]};
                W_NEG:   pe_d[i] = -{i_data[i][DATA_WIDTH-1], i_data[i]};
                default: pe_d[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_v  <= 1'b0;
            pe_q  <= '0;
            pe_sb <= '0;
        end else if (en) begin
            pe_v <= accept;
            if (accept) begin
                pe_q  <= pe_d;
                pe_sb <= {i_first, i_last};
            end
        end
    end

    logic             t_v;
    logic [SUM_W-1:0] t_sum;
    logic [1:0]       t_sb;

    tdpu_add_tree #(
        .LEN      (LEN),
        .IN_WIDTH (PE_W),
        .SB_W     (2)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (pe_v),
        .in_data   (pe_q),
        .in_sb     (pe_sb),
        .out_valid (t_v),
        .out_sum   (t_sum),
        .out_sb    (t_sb)
    );

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        ovf_q;
    logic                        ovf_d;
    logic [15:0]                 beats_q;
    logic [15:0]                 beats_d;
    logic signed [63:0]          base;
    logic signed [63:0]          tot;
    acc_res_t                    res;
    logic                        t_first;
    logic                        t_last;

    assign t_first = t_sb[1];
    assign t_last  = t_sb[0];

    always_comb begin
        base    = t_first ? 64'sd0 : 64'(acc_q);
        tot     = base + 64'($signed(t_sum));
        res     = acc_limit(tot, ACC_WIDTH, SAT_EN != 0);
        acc_d   = ACC_WIDTH'(res.val);
        ovf_d   = t_first ? res.ovf : (ovf_q | res.ovf);
        beats_d = t_first ? 16'd1
                : (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
    end

    // Result holds until taken; a fresh last beat may replace it on that edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            beats_q    <= '0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_beats    <= '0;
        end else if (en) begin
            if (t_v) begin
                acc_q   <= acc_d;
                ovf_q   <= ovf_d;
                beats_q <= beats_d;
            end
            if (t_v && t_last) begin
                o_valid    <= 1'b1;
                o_result   <= acc_d;
                o_overflow <= ovf_d;
                o_beats    <= beats_d;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdpu_vec_acc_core.sv
// Scoreboard bench for tdpu_vec_acc_core: three DUT variants share stimulus.
// A plain-arithmetic reference predicts each group result.
module tb_tdpu_vec_acc_core;
    import tdpu_vec_acc_core_pkg::*;

    localparam int LEN = 16;
    localparam int DW  = 8;
    localparam int ND  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    i_valid = 1'b0;
    logic                    i_first = 1'b0;
    logic                    i_last = 1'b0;
    logic                    i_load_weight = 1'b0;
    logic                    i_wswap = 1'b0;
    logic                    i_ready = 1'b1;
    logic [LEN-1:0][DW-1:0]  i_data = '0;
    weight_t [LEN-1:0]       i_weight;

    logic        o_ready_v [ND];
    logic        o_valid_v [ND];
    logic        o_ovf_v   [ND];
    logic [15:0] o_beats_v [ND];
    logic [31:0] r32;
    logic [11:0] r12s;
    logic [11:0] r12w;

    tdpu_vec_acc_core #(.LEN(LEN), .DATA_WIDTH(DW), .ACC_WIDTH(32), .SAT_EN(1)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_v[0]),
        .i_data(i_data), .i_first(i_first), .i_last(i_last),
        .i_load_weight(i_load_weight), .i_weight(i_weight), .i_wswap(i_wswap),
        .o_valid(o_valid_v[0]), .i_ready(i_ready), .o_result(r32),
        .o_overflow(o_ovf_v[0]), .o_beats(o_beats_v[0])
    );

    tdpu_vec_acc_core #(.LEN(LEN), .DATA_WIDTH(DW), .ACC_WIDTH(12), .SAT_EN(1)) u_s12 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_v[1]),
        .i_data(i_data), .i_first(i_first), .i_last(i_last),
        .i_load_weight(i_load_weight), .i_weight(i_weight), .i_wswap(i_wswap),
        .o_valid(o_valid_v[1]), .i_ready(i_ready), .o_result(r12s),
        .o_overflow(o_ovf_v[1]), .o_beats(o_beats_v[1])
    );

    tdpu_vec_acc_core #(.LEN(LEN), .DATA_WIDTH(DW), .ACC_WIDTH(12), .SAT_EN(0)) u_w12 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready_v[2]),
        .i_data(i_data), .i_first(i_first), .i_last(i_last),
        .i_load_weight(i_load_weight), .i_weight(i_weight), .i_wswap(i_wswap),
        .o_valid(o_valid_v[2]), .i_ready(i_ready), .o_result(r12w),
        .o_overflow(o_ovf_v[2]), .o_beats(o_beats_v[2])
    );

    typedef struct {
        longint res;
        bit     ovf;
        int     beats;
    } exp_t;

    exp_t    exp_q [ND][$];
    weight_t act_m [LEN];
    weight_t shd_m [LEN];
    longint  m_acc [ND];
    bit      m_ovf [ND];
    int      m_beats [ND];
    int      aw_m [ND] = '{32, 12, 12};
    bit      sat_m [ND] = '{1'b1, 1'b1, 1'b0};
    longint  last_res [ND];
    bit      last_ovf [ND];
    int      last_beats [ND];
    int      checks = 0;
    int      failures = 0;
    bit      rnd_ready = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint dut_res(input int d);
        case (d)
            0:       return longint'($signed(r32));
            1:       return longint'($signed(r12s));
            default: return longint'($signed(r12w));
        endcase
    endfunction

    function automatic longint lane(input weight_t w, input logic [DW-1:0] x);
        longint v;
        v = longint'($signed(x));
        if (w == W_POS) return v;
        if (w == W_NEG) return -v;
        return 0;
    endfunction

    // Reference: dot product, then range-limit to each variant's width
    task automatic model_accept(input logic [LEN-1:0][DW-1:0] x, input bit f, input bit l);
        longint s, t, hi, lo, m;
        bit o;
        s = 0;
        for (int i = 0; i < LEN; i++) s += lane(act_m[i], x[i]);
        for (int d = 0; d < ND; d++) begin
            m  = 64'sd1 <<< aw_m[d];
            hi = m / 2 - 1;
            lo = -(m / 2);
            t  = (f ? 0 : m_acc[d]) + s;
            o  = (t > hi) || (t < lo);
            if (o && sat_m[d]) t = (t > hi) ? hi : lo;
            else if (o) begin
                t = t & (m - 1);
                if (t > hi) t -= m;
            end
            m_acc[d]   = t;
            m_ovf[d]   = f ? o : (m_ovf[d] | o);
            m_beats[d] = f ? 1 : (m_beats[d] < 65535 ? m_beats[d] + 1 : 65535);
            if (l) exp_q[d].push_back('{t, m_ovf[d], m_beats[d]});
        end
    endtask

    task automatic tick(output bit acc);
        logic [LEN-1:0][DW-1:0] x;
        weight_t [LEN-1:0]      w;
        bit f, l, ld, sw;
        #1;
        acc = i_valid && o_ready_v[0];
        x = i_data; f = i_first; l = i_last;
        ld = i_load_weight; sw = i_wswap; w = i_weight;
        @(posedge clk);
        #1;
        if (acc) model_accept(x, f, l);
        for (int i = 0; i < LEN; i++) begin
            if (sw) act_m[i] = ld ? w[i] : shd_m[i];
            if (ld) shd_m[i] = w[i];
        end
        i_valid = 1'b0;
        i_load_weight = 1'b0;
        i_wswap = 1'b0;
        if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [LEN-1:0][DW-1:0] x, input bit f, input bit l);
        bit a;
        int n;
        n = 0;
        a = 1'b0;
        while (!a && n < 100) begin
            i_valid = 1'b1; i_data = x; i_first = f; i_last = l;
            tick(a);
            n++;
        end
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) tick(a);
    endtask

    task automatic drain();
        int n;
        bit a;
        n = 0;
        rnd_ready = 1'b0;
        i_ready = 1'b1;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 300) begin
            tick(a);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    function automatic logic [LEN-1:0][DW-1:0] splat(input int v);
        logic [LEN-1:0][DW-1:0] x;
        for (int i = 0; i < LEN; i++) x[i] = DW'(v);
        return x;
    endfunction

    task automatic set_weights(input int mode);
        for (int i = 0; i < LEN; i++) begin
            case (mode)
                0: i_weight[i] = W_POS;
                1: i_weight[i] = W_NEG;
                default: i_weight[i] = i[0] ? W_NEG : W_POS;
            endcase
        end
    endtask

    function automatic weight_t rw();
        case ($urandom_range(0, 3))
            0: return W_ZERO;
            1: return W_POS;
            2: return W_NEG;
            default: return weight_t'(2'b10);
        endcase
    endfunction

    task automatic load_active(input int mode);
        bit a;
        set_weights(mode);
        i_load_weight = 1'b1;
        i_wswap = 1'b1;
        tick(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0; i_load_weight = 1'b0; i_wswap = 1'b0;
        #2;
        for (int d = 0; d < ND; d++) begin
            chk("rst_valid", o_valid_v[d], 0);
            chk("rst_result", dut_res(d), 0);
            chk("rst_ovf", o_ovf_v[d], 0);
            chk("rst_beats", o_beats_v[d], 0);
            chk("rst_ready", o_ready_v[d], 1);
            exp_q[d].delete();
            m_acc[d] = 0; m_ovf[d] = 0; m_beats[d] = 0;
        end
        for (int i = 0; i < LEN; i++) begin
            act_m[i] = W_ZERO;
            shd_m[i] = W_ZERO;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare whenever a result is presented, pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                if (o_valid_v[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("unexpected_result", dut_res(d), -1);
                    end else begin
                        chk("result", dut_res(d), exp_q[d][0].res);
                        chk("overflow", o_ovf_v[d], exp_q[d][0].ovf);
                        chk("beats", o_beats_v[d], exp_q[d][0].beats);
                        if (i_ready) begin
                            last_res[d] = dut_res(d);
                            last_ovf[d] = o_ovf_v[d];
                            last_beats[d] = o_beats_v[d];
                            void'(exp_q[d].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bit a;
        set_weights(0);
        do_reset();

        // Single beat, all +1, latency counted including the accept edge
        load_active(0);
        send(splat(127), 1, 1);
        n = 1;
        while (!o_valid_v[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_edges", n, 6);
        drain();
        chk("t1_result", last_res[0], 2032);
        chk("t1_beats", last_beats[0], 1);
        chk("t1_ovf", last_ovf[0], 0);

        // Alternating signs cancel; all -1 on -128 gives +2048
        load_active(2);
        send(splat(-128), 1, 1);
        drain();
        chk("t2_alt", last_res[0], 0);
        load_active(1);
        send(splat(-128), 1, 1);
        drain();
        chk("t2_neg", last_res[0], 2048);

        // Three-beat group
        load_active(0);
        send(splat(1), 1, 0);
        send(splat(2), 0, 0);
        send(splat(3), 0, 1);
        drain();
        chk("t3_result", last_res[0], 96);
        chk("t3_beats", last_beats[0], 3);

        // Backpressure with results pending
        send(splat(5), 1, 1);
        send(splat(6), 1, 1);
        i_ready = 1'b0;
        send(splat(7), 1, 1);
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1; i_data = splat(9); i_first = 1'b1; i_last = 1'b1;
            tick(a);
            if (o_valid_v[0]) chk("bp_ready_low", o_ready_v[0], 0);
        end
        drain();
        chk("t4_last", last_res[0], 144);

        // Double buffer: shadow load while streaming, swap before beat 3
        set_weights(1);
        i_load_weight = 1'b1;
        send(splat(10), 1, 0);
        send(splat(10), 0, 0);
        i_wswap = 1'b1;
        tick(a);
        send(splat(10), 0, 1);
        drain();
        chk("t5_result", last_res[0], 160);
        // Swap on the accept edge still uses the old bank
        set_weights(0);
        i_load_weight = 1'b1;
        tick(a);
        i_wswap = 1'b1;
        send(splat(10), 1, 1);
        drain();
        chk("t5_swap_old", last_res[0], -160);
        send(splat(10), 1, 1);
        drain();
        chk("t5_swap_new", last_res[0], 160);

        // 12-bit saturate and wrap variants
        send(splat(127), 1, 0);
        send(splat(127), 0, 1);
        drain();
        chk("t6_wide", last_res[0], 4064);
        chk("t6_sat", last_res[1], 2047);
        chk("t6_sat_ovf", last_ovf[1], 1);
        chk("t6_wrap", last_res[2], -32);
        chk("t6_wrap_ovf", last_ovf[2], 1);

        // Reset mid-group; next group starts clean
        send(splat(50), 1, 0);
        send(splat(50), 0, 0);
        do_reset();
        load_active(0);
        send(splat(3), 1, 1);
        drain();
        for (int d = 0; d < ND; d++) begin
            chk("t6_after_rst", last_res[d], 48);
            chk("t6_after_rst_beats", last_beats[d], 1);
        end

        // Randomized traffic with random backpressure and weight updates
        rnd_ready = 1'b1;
        for (int b = 0; b < 400; b++) begin
            logic [LEN-1:0][DW-1:0] x;
            for (int i = 0; i < LEN; i++) begin
                x[i] = DW'($urandom);
                i_weight[i] = rw();
            end
            i_load_weight = ($urandom_range(0, 3) == 0);
            i_wswap = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) idle(1);
            else send(x, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        drain();
        for (int d = 0; d < ND; d++) chk("final_empty", exp_q[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1);
    end

endmodule
